// File: rtl/fifo_stream_reader_if.sv
// Byte stream handshake between fifo_stream_reader and downstream transmit logic.
// The producer drives data/valid/last; the consumer drives ready.
interface fifo_stream_reader_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side controller for the 16-entry byte FIFO: hides its one-cycle read latency
// behind a 2-entry output buffer and marks the last byte of each FRAME_LEN-byte frame.
module fifo_stream_reader #(
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_wr_en,
  input  logic [7:0]            fifo_dout,
  output logic                  fifo_rd_en,
  fifo_stream_reader_if.master  m,
  output logic                  busy
);

  localparam int unsigned           CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0]      LAST_POS = CNT_W'(FRAME_LEN - 1);

  logic [1:0]       count;
  logic             inflight;
  logic [7:0]       head_q;
  logic [7:0]       skid_q;
  logic [CNT_W-1:0] byte_cnt;

  logic             valid;
  logic             pop;
  logic [1:0]       level;

  assign valid = (count != 2'd0);
  assign pop   = valid && m.m_ready;

  // Occupancy the buffer will have once this cycle's pop retires, counting the
  // byte already on its way from the FIFO; a new read is only safe below 2.
  assign level = count + 2'(inflight) - 2'(pop);

  // Gated by reset_n so the FIFO sees no read request while the reader is held in reset.
  assign fifo_rd_en = reset_n && enable && !fifo_empty && !fifo_wr_en && (level < 2'd2);

  // NOTE: head/skid are ordinary registers, not a memory array, so they take the
  // asynchronous reset as well; m_data must read 0x00 while reset is asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= 2'd0;
      inflight <= 1'b0;
      head_q   <= 8'h00;
      skid_q   <= 8'h00;
      byte_cnt <= '0;
    end else begin
      // NOTE: every state update here is non-blocking so the case below sees the
      // pre-edge count/inflight regardless of statement order.
      inflight <= fifo_rd_en;

      unique case ({pop, inflight})
        2'b01: begin
          if (count == 2'd0) head_q <= fifo_dout;
          else               skid_q <= fifo_dout;
          count <= count + 2'd1;
        end
        2'b10: begin
          head_q <= skid_q;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head_q <= skid_q;
            skid_q <= fifo_dout;
          end else begin
            head_q <= fifo_dout;
          end
        end
        default: ;
      endcase

      if (pop) byte_cnt <= (byte_cnt == LAST_POS) ? '0 : byte_cnt + 1'b1;
    end
  end

  assign m.m_data  = head_q;
  assign m.m_valid = valid;
  assign m.m_last  = valid && (byte_cnt == LAST_POS);
  assign busy      = valid || inflight;

  a_no_overfill: assert property (
    @(posedge clk) disable iff (!reset_n)
    ({1'b0, count} + {2'b00, inflight}) <= 3'd2
  );

  a_stall_stable: assert property (
    @(posedge clk) disable iff (!reset_n)
    (m.m_valid && !m.m_ready) |=> (m.m_valid && $stable(m.m_data))
  );

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side controller for the team's 16-entry synchronous byte FIFO. It pops bytes from the FIFO and hides the FIFO's one-cycle read latency. It presents the bytes as a valid/ready stream through a 2-entry output buffer, at up to one byte per cycle. It also counts bytes into fixed-length frames and flags the last byte of each frame, so downstream transmit logic can consume FIFO contents without handling empty/read timing.

## Interface
- FRAME_LEN, default 16: bytes per frame, legal range 1..256; m_last marks byte FRAME_LEN-1 of each frame.
- clk  input  1  rising-edge clock shared with the FIFO.
- reset_n  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- enable  input  1  permits new FIFO reads; already-fetched data drains regardless.
- fifo_empty  input  1  FIFO empty flag.
- fifo_wr_en  input  1  FIFO write-side write enable, monitored only (the FIFO gives writes priority over reads).
- fifo_dout  input  8  FIFO read data, valid in the cycle after an accepted read.
- fifo_rd_en  output  1  FIFO read request (combinational).
- m_data  output  8  stream data (head of output buffer).
- m_valid  output  1  stream data valid.
- m_last  output  1  current m_data is last byte of a frame.
- m_ready  input  1  downstream accepts when m_valid && m_ready.
- busy  output  1  buffer non-empty or a read in flight.

## Operation
**State**
- count (0..2): output buffer occupancy.
- inflight (1 bit): a read was accepted in the previous cycle.
- byte_cnt (0..FRAME_LEN-1): position within the current frame.

**Reading from the FIFO**
- pop = m_valid && m_ready.
- fifo_rd_en = enable && !fifo_empty && !fifo_wr_en && (count + inflight - pop < 2).
- fifo_rd_en is never high while fifo_wr_en is high, so every asserted rd_en is an accepted read.
- inflight <= fifo_rd_en.
- If inflight is set, fifo_dout is written into the buffer tail at that edge.

**Output buffer**
- 2-entry FIFO: head register plus skid register.
- Simultaneous pop and capture: the skid moves to the head (or the capture goes to the head if skid is empty), and the new byte goes to the tail. Order is preserved and nothing is dropped.
- m_valid = (count != 0). m_data = head. m_data is held stable while m_valid && !m_ready.

**Framing**
- byte_cnt increments on pop and wraps from FRAME_LEN-1 to 0.
- m_last = m_valid && (byte_cnt == FRAME_LEN-1).
- FRAME_LEN=1: m_last is high on every valid byte.

**Enable and busy**
- enable low: blocks new reads only; inflight and buffered bytes still complete and drain.
- busy = (count != 0) || inflight.

**Reset**
- reset_n low clears count, inflight, byte_cnt and the data registers to 0, asynchronously.
- A read in flight when reset asserts is discarded. The FIFO has already consumed that byte; this loss is accepted behaviour.

## Timing
- Reset values: fifo_rd_en=0, m_data=0x00, m_valid=0, m_last=0, busy=0.
- Latency: fifo_rd_en high in cycle c, so fifo_dout is valid in cycle c+1, captured at the end of c+1, and m_valid is high in cycle c+2.
- Throughput: with m_ready held high and the FIFO non-empty, fifo_rd_en and pop each occur every cycle. Steady state is count=1, inflight=1.
- Backpressure: with m_ready low, at most 2 reads are issued (count + inflight ≤ 2 always). fifo_rd_en then stays low until a pop.
- fifo_empty rising: no read that cycle; the in-flight byte is still captured.
- Reset is asynchronous assert. Operation resumes on the first clk edge after reset_n rises (synchronous deassert expected upstream).

## Test plan
- **Reset:** reset_n=0 mid-traffic → fifo_rd_en, m_valid, m_last, busy = 0 and m_data=0x00 immediately, without waiting for a clock edge.
- **Streaming:** FIFO preloaded 0xA1,0xA2,0xA3; enable=1, m_ready=1 → fifo_rd_en high cycles 0-2; m_valid high cycles 2-4 carrying 0xA1,0xA2,0xA3 in order; busy low from cycle 5.
- **Backpressure:** FIFO holds 5 bytes 0x10..0x14, m_ready=0.
  - Expect exactly 2 fifo_rd_en pulses; m_data holds 0x10 stable.
  - Then m_ready=1 → all 5 bytes delivered in order, no duplicates.
- **Write priority:** FIFO non-empty, fifo_wr_en=1 for 3 cycles → fifo_rd_en=0 in those cycles and inflight never set; reads resume the cycle after fifo_wr_en drops.
- **Framing:** FRAME_LEN=4, 9 bytes streamed → m_last high on bytes 4 and 8 only; a following 3-byte frame ends with m_last on its 3rd byte (byte_cnt continues from 1).
- **Reset and enable mid-stream:**
  - reset_n pulsed low after 2 of 6 bytes → resumes with the next FIFO byte after the lost in-flight byte; byte_cnt restarts at 0.
  - enable=0 → no new reads, buffered bytes drain, then busy=0.
